// File: rtl/keyin_pkg.sv
// Shared types, default constants and helpers for the hex key entry front end.
`default_nettype none

package keyin_pkg;

  localparam int CLK_DIV_DEFAULT    = 100000;
  localparam int STABLE_CNT_DEFAULT = 10;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_EMIT = 2'd2
  } keyin_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } onehot_t;

  // valid is set only when exactly one bit of v is high; idx is then its position.
  function automatic onehot_t onehot_to_idx(input logic [15:0] v);
    onehot_t     r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        r.idx = 4'(i);
        n++;
      end
    end
    r.valid = (n == 1);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hex_key_encoder_if.sv
// Board-input / command-output bundle between the key encoder and its neighbours.
`default_nettype none

interface hex_key_encoder_if;
  logic [15:0] sw;
  logic        del_btn;
  logic [3:0]  hex;
  logic        add;
  logic        del;
  logic        multi;

  modport master (
    input  sw,
    input  del_btn,
    output hex,
    output add,
    output del,
    output multi
  );

  modport slave (
    output sw,
    output del_btn,
    input  hex,
    input  add,
    input  del,
    input  multi
  );
endinterface

`default_nettype wire

// File: rtl/vec_debounce.sv
// Synchronises a raw input vector and accepts it once it has been steady for
// STABLE_CNT consecutive sample ticks. STABLE_CNT must be at least 2.
`default_nettype none

module vec_debounce #(
  parameter int W          = 17,
  parameter int CLK_DIV    = 100000,
  parameter int STABLE_CNT = 10
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_sample,
  output logic         o_accept
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam logic [TW-1:0] c_TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [SW-1:0] c_STABLE_MAX = SW'(STABLE_CNT);
  localparam logic [SW-1:0] c_STABLE_PRE = SW'(STABLE_CNT - 1);

  logic [W-1:0]  r_sync1;
  logic [W-1:0]  r_sync2;
  logic [W-1:0]  r_sample;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_stable;
  logic          w_tick;
  logic          w_match;

  assign w_tick   = (r_tick_cnt == c_TICK_LAST);
  assign w_match  = (r_sync2 == r_sample);
  // Fires on the tick that moves the counter onto STABLE_CNT, so once per steady run.
  assign o_accept = w_tick && w_match && (r_stable == c_STABLE_PRE);
  assign o_sample = r_sample;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sample   <= '0;
      r_tick_cnt <= '0;
      r_stable   <= '0;
    end else begin
      r_sync1    <= i_din;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        if (!w_match) begin
          r_sample <= r_sync2;
          r_stable <= SW'(1);
        end else if (r_stable != c_STABLE_MAX) begin
          r_stable <= r_stable + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hex_key_encoder.sv
// Turns debounced switch toggles and delete presses into single-cycle
// add / del / multi command pulses for the hex-digit entry register.
`default_nettype none

module hex_key_encoder
  import keyin_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int STABLE_CNT = STABLE_CNT_DEFAULT,
  parameter int NSW        = 16
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  hex_key_encoder_if.master     bus
);

  localparam int W = NSW + 1;

  localparam logic [1:0] ST_INIT = S_INIT;
  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_EMIT = S_EMIT;

  logic [W-1:0] w_sample;
  logic         w_accept;
  logic [W-1:0] w_diff;
  logic         w_del_rise;
  onehot_t      w_oh;

  logic [1:0]   r_state;
  logic [W-1:0] r_committed;
  logic [3:0]   r_hex;
  logic         r_add;
  logic         r_del;
  logic         r_multi;

  vec_debounce #(
    .W          (W),
    .CLK_DIV    (CLK_DIV),
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk      (sys_clk),
    .rstn     (rstn),
    .i_din    ({bus.del_btn, bus.sw}),
    .o_sample (w_sample),
    .o_accept (w_accept)
  );

  assign w_diff     = w_sample ^ r_committed;
  assign w_del_rise = w_diff[W-1] & w_sample[W-1];
  assign w_oh       = onehot_to_idx(w_diff[15:0]);

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      r_state     <= ST_INIT;
      r_committed <= '0;
      r_hex       <= '0;
      r_add       <= 1'b0;
      r_del       <= 1'b0;
      r_multi     <= 1'b0;
    end else begin
      r_add   <= 1'b0;
      r_del   <= 1'b0;
      r_multi <= 1'b0;
      case (r_state)
        ST_INIT: begin
          // Power-up switch positions become the baseline without a pulse.
          if (w_accept) begin
            r_committed <= w_sample;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_committed <= w_sample;
            if (w_del_rise) begin
              r_del   <= 1'b1;
              r_state <= ST_EMIT;
            end else if (w_oh.valid) begin
              r_hex   <= w_oh.idx;
              r_add   <= 1'b1;
              r_state <= ST_EMIT;
            end else if (|w_diff[15:0]) begin
              r_multi <= 1'b1;
              r_state <= ST_EMIT;
            end
          end
        end
      endcase
    end
  end

  assign bus.hex   = r_hex;
  assign bus.add   = r_add;
  assign bus.del   = r_del;
  assign bus.multi = r_multi;

endmodule

`default_nettype wire

// File: tb/tb_hex_key_encoder.sv
// Directed bench for hex_key_encoder with a cycle-level reference model.
`default_nettype none

module tb_hex_key_encoder;
  import keyin_pkg::*;

  localparam int CD = 4;
  localparam int SC = 3;

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;

  hex_key_encoder_if bus ();

  hex_key_encoder #(
    .CLK_DIV    (CD),
    .STABLE_CNT (SC),
    .NSW        (16)
  ) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int n_add, n_del, n_multi;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw inputs reach the filter two edges late, sample ticks
  // land on every CD-th edge after reset, a value is accepted when it has been
  // seen on SC consecutive ticks, and accepted changes are classified.
  int          k;
  logic [16:0] d1, d2;
  logic [16:0] m_last;
  int          m_run;
  logic [16:0] m_comm;
  bit          m_init;
  bit          started = 0;
  logic [3:0]  e_hex;
  bit          e_add, e_del, e_multi;

  always @(posedge sys_clk) begin
    logic [16:0] rawv, v, diff;
    int ones;
    rawv    = {bus.del_btn, bus.sw};
    e_add   = 0;
    e_del   = 0;
    e_multi = 0;
    if (!rstn) begin
      k = 0; d1 = '0; d2 = '0;
      m_last = '0; m_run = 0; m_comm = '0; m_init = 1; e_hex = '0;
      started = 1;
    end else begin
      k++;
      v  = d2;
      d2 = d1;
      d1 = rawv;
      if (k % CD == 0) begin
        if (v == m_last) begin
          if (m_run < SC) begin
            m_run++;
            if (m_run == SC) begin
              if (m_init) begin
                m_comm = v;
                m_init = 0;
              end else begin
                diff   = v ^ m_comm;
                m_comm = v;
                ones   = $countones(diff[15:0]);
                if (diff[16] && v[16]) e_del = 1;
                else if (ones == 1) begin
                  for (int i = 0; i < 16; i++) if (diff[i]) e_hex = 4'(i);
                  e_add = 1;
                end else if (ones > 1) e_multi = 1;
              end
            end
          end
        end else begin
          m_last = v;
          m_run  = 1;
        end
      end
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      chk("hex",   int'(bus.hex),   int'(e_hex));
      chk("add",   int'(bus.add),   int'(e_add));
      chk("del",   int'(bus.del),   int'(e_del));
      chk("multi", int'(bus.multi), int'(e_multi));
      if (bus.add)   n_add++;
      if (bus.del)   n_del++;
      if (bus.multi) n_multi++;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * CD) @(posedge sys_clk);
    #1;
  endtask

  task automatic clr();
    n_add = 0; n_del = 0; n_multi = 0;
  endtask

  int lat;

  initial begin
    bus.sw = 16'h0005; bus.del_btn = 1'b0; rstn = 1'b0;
    clr();
    repeat (3) @(posedge sys_clk);
    #1 rstn = 1'b1;

    // Power-up baseline produces nothing.
    wait_ticks(20);
    chk("rst_no_add",   n_add,   0);
    chk("rst_no_del",   n_del,   0);
    chk("rst_no_multi", n_multi, 0);
    chk("rst_hex",      int'(bus.hex), 0);
    clr();
    bus.sw[9] = 1'b1;
    wait_ticks(5);
    chk("sw9_add_cnt", n_add, 1);
    chk("sw9_hex",     int'(bus.hex), 9);

    // Bounce rejection, then a clean edge.
    clr();
    bus.sw[3] = 1'b1; wait_ticks(1);
    bus.sw[3] = 1'b0; wait_ticks(6);
    chk("bounce_no_pulse", n_add + n_del + n_multi, 0);
    bus.sw[3] = 1'b1;
    lat = 0;
    while (n_add == 0 && lat < 40) begin
      @(posedge sys_clk);
      lat++;
    end
    #1;
    chk("sw3_latency_le15", int'((lat - 1) <= 15), 1);
    chk("sw3_hex", int'(bus.hex), 3);
    wait_ticks(3);
    clr();
    bus.sw[3] = 1'b0;
    wait_ticks(5);
    chk("sw3_back_add_cnt", n_add, 1);
    chk("sw3_back_hex",     int'(bus.hex), 3);

    // Delete press and release.
    clr();
    bus.del_btn = 1'b1; wait_ticks(5);
    bus.del_btn = 1'b0; wait_ticks(5);
    chk("del_cnt",     n_del, 1);
    chk("del_no_add",  n_add, 0);
    chk("del_hex_kept", int'(bus.hex), 3);

    // Delete and a switch flip arriving together.
    clr();
    bus.del_btn = 1'b1; bus.sw[0] = ~bus.sw[0];
    wait_ticks(5);
    chk("sim_del_cnt",  n_del,   1);
    chk("sim_no_add",   n_add,   0);
    chk("sim_no_multi", n_multi, 0);
    bus.del_btn = 1'b0; wait_ticks(5);
    clr();
    bus.sw[1] = ~bus.sw[1];
    wait_ticks(5);
    chk("sw1_add_cnt", n_add, 1);
    chk("sw1_hex",     int'(bus.hex), 1);

    // Two switches at once.
    clr();
    bus.sw[2] = ~bus.sw[2]; bus.sw[15] = ~bus.sw[15];
    wait_ticks(5);
    chk("multi_cnt",  n_multi, 1);
    chk("multi_no_add", n_add, 0);
    chk("multi_hex_kept", int'(bus.hex), 1);

    // Reset while a change is still being filtered.
    clr();
    bus.sw[7] = ~bus.sw[7];
    wait_ticks(2);
    rstn = 1'b0;
    @(posedge sys_clk); #1;
    rstn = 1'b1;
    wait_ticks(8);
    chk("midrst_no_add", n_add, 0);
    chk("midrst_hex",    int'(bus.hex), 0);
    bus.sw[7] = ~bus.sw[7];
    wait_ticks(5);
    chk("sw7_add_cnt", n_add, 1);
    chk("sw7_hex",     int'(bus.hex), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/hex_key_encoder.md
Name: hex_key_encoder

Overview:
- Front-end producer for the hex-digit entry shift register. It drives that register's `hex`, `add` and `del` inputs.
- Converts 16 board slide switches and one delete push-button into clean single-cycle command pulses.
- Each debounced toggle of switch k emits `add` with `hex` = k. Each debounced press of the delete button emits `del`.
- Sits between the board I/O pins and the data-entry shift register.

Parameters:
- CLK_DIV, default 100000: sys_clk cycles per sample tick (1 ms at 100 MHz).
- STABLE_CNT, default 10: number of consecutive identical samples required before an input vector is accepted.
- NSW, default 16: switch count. Fixed at 16; `hex` is 4 bits.

Ports:
- sys_clk  in  1  system clock, single clock domain.
- rstn  in  1  reset, synchronous, active-low.
- sw  in  16  raw slide switches, asynchronous to sys_clk.
- del_btn  in  1  raw delete button, asynchronous, active-high.
- hex  out  4  index of the last toggled switch; held between pulses.
- add  out  1  one-cycle pulse: append `hex`.
- del  out  1  one-cycle pulse: delete last digit.
- multi  out  1  one-cycle pulse: more than one switch changed within one accepted sample; no `add` is issued.

Behaviour:
- Reset: rstn=0 sampled at a sys_clk edge. Then:
  - `hex`=0, `add`=0, `del`=0, `multi`=0.
  - Tick counter, stable counter, synchronizers, sample register and committed register all cleared.
  - FSM enters INIT.
  - Reset asserted mid-operation aborts any pending pulse; no pulse is issued afterwards for the aborted event.
- Synchronizer: two flip-flop stages on {del_btn, sw}, forming a 17-bit vector `v`.
- Tick:
  - Counter runs 0..CLK_DIV-1.
  - `tick` is high for one cycle when the count equals CLK_DIV-1; the counter wraps to 0 on that cycle.
- Debounce, evaluated on each tick:
  - If `v` == sample register: stable counter increments, saturating at STABLE_CNT.
  - Otherwise: sample register <= `v` and stable counter <= 1.
  - `accept` is a one-cycle pulse on the tick where the stable counter transitions to STABLE_CNT. It fires only once per stable period.
- FSM states are INIT, IDLE and EMIT.
- INIT:
  - On `accept`: committed <= sample, then go to IDLE.
  - No pulse is issued, so the switch positions at power-up form the baseline.
- IDLE:
  - On `accept`: form diff = sample ^ committed, then committed <= sample.
  - If diff is 0, stay in IDLE.
  - Otherwise latch the decision and go to EMIT.
- EMIT lasts exactly one cycle. Outputs are registered, so each pulse appears on the cycle after the `accept` cycle. Then return to IDLE. Decision priority:
  1. Delete rising (committed bit16 0->1): `del`=1. Any switch changes in the same diff are absorbed: no `add`, no `multi`.
  2. Else exactly one sw bit k changed, in either direction: `hex` <= k and `add`=1 in the same cycle.
  3. Else more than one sw bit changed: `multi`=1; `hex` is unchanged.
  4. A delete-button release alone (1->0) issues no pulse.
- At most one of `add`/`del`/`multi` is high in any cycle. Each is high for exactly one cycle.
- Minimum spacing between pulses is one accepted sample.
- Latency from a clean input edge to its pulse: 2 + (time to next tick) + (STABLE_CNT-1)*CLK_DIV + 1 cycles.
- A bounce shorter than STABLE_CNT ticks never produces a pulse.
- Width: the stable counter is $clog2(STABLE_CNT+1) bits; the tick counter is $clog2(CLK_DIV) bits.

Decomposition:
- Shared package `keyin_pkg`:
  - FSM state enum {INIT, IDLE, EMIT}.
  - Default constants CLK_DIV_DEFAULT and STABLE_CNT_DEFAULT.
  - Function onehot_to_idx, 16->4 bits, with a valid flag indicating exactly one bit set.
- One sub-module, `vec_debounce`: parameterised width W, CLK_DIV and STABLE_CNT. It contains the synchronizer, tick counter, sample register and stable counter, and outputs `sample[W-1:0]` and `accept`.
- `hex_key_encoder` itself holds the committed register, FSM and output registers.

Test Plan (bench uses CLK_DIV=4, STABLE_CNT=3):
- Reset handling:
  - Stimulus: sw=16'h0005 held through reset, then wait 20 ticks.
  - Required: no pulse; `hex`=0.
  - Then flip sw[9]. Required: exactly one `add` with `hex`=9.
- Bounce rejection and acceptance:
  - Stimulus: sw[3] toggles 0/1/0 with each level held for 1 tick.
  - Required: no pulse.
  - Then hold sw[3]=1. Required: one `add` with `hex`=4'h3, after ≤ 2+4+8+1 cycles.
  - Then return sw[3] to 0. Required: second `add`, `hex`=3.
- Delete:
  - Stimulus: del_btn held high for 5 ticks, then low.
  - Required: exactly one `del` pulse on press; none on release; `hex` unchanged.
- Simultaneous events:
  - Stimulus: del_btn rises on the same cycle that sw[0] flips.
  - Required: `del`=1 only, no `add`.
  - Then a later sw[1] flip. Required: `add` with `hex`=1; sw[0] is not re-reported.
- Multi-change:
  - Stimulus: sw[2] and sw[15] flip on the same cycle.
  - Required: `multi`=1 for one cycle; `add`=0; `hex` retains its previous value.
- Reset mid-operation:
  - Stimulus: flip sw[7] and wait 2 ticks, then assert rstn=0 for 1 cycle; sw[7] remains flipped.
  - Required: no `add` is ever issued for sw[7]. Afterwards flipping sw[7] back gives `add` with `hex`=7.
